uart_tx_arb: RTL and testbench
==============================

UART_TX_ARB -- requirements
Module: uart_tx_arb

Interface
REQ-001 Parameter NREQ, default 4, SHALL set the number of requesters sharing one UART transmitter (range 2..8).
REQ-002 Parameter START_TIMEOUT, default 15, SHALL set the max cycles to wait for uart_is_transmitting after launch.
REQ-003 clk  in  1  single clock; all state changes on its rising edge.
REQ-004 rst  in  1  reset; asynchronous, active-high.
REQ-005 req_valid  in  NREQ  per-requester byte-pending flag.
REQ-006 req_data  in  NREQ*8  per-requester byte, requester i at bits [8i+7:8i].
REQ-007 req_ready  out  NREQ  one-hot acceptance pulse.
REQ-008 uart_transmit  out  1  drives UART transmit input.
REQ-009 uart_tx_byte  out  8  drives UART tx_byte input.
REQ-010 uart_is_transmitting  in  1  UART busy flag.
REQ-011 grant_id  out  clog2(NREQ)  index of requester owning the current transfer.
REQ-012 busy  out  1  high whenever state is not IDLE.
REQ-013 timeout_err  out  1  one-cycle pulse on launch timeout.

Function
REQ-014 FSM SHALL have states IDLE, LAUNCH, WAIT_DONE.
REQ-015 IDLE: if any req_valid=1 and uart_is_transmitting=0, next edge SHALL go to LAUNCH, load uart_tx_byte with winner's data, set grant_id, assert req_ready[winner] for exactly one cycle, assert uart_transmit.
REQ-016 IDLE with uart_is_transmitting=1 SHALL NOT grant; requests wait.
REQ-017 Handshake: transfer completes at the edge where req_ready[i]=1; req_data[i] SHALL be stable from req_valid[i] rise until that edge; dropping req_valid before grant cancels with no side effect.
REQ-018 Arbitration SHALL be round-robin: search starts at last_grant+1 mod NREQ, wraps at NREQ-1 to 0; last_grant updated on each grant.
REQ-019 LAUNCH: uart_transmit SHALL stay 1 until uart_is_transmitting=1 is sampled, then drop to 0 on the next edge and state SHALL go to WAIT_DONE.
REQ-020 LAUNCH cycle counter SHALL count from 0; if it reaches START_TIMEOUT with uart_is_transmitting=0, SHALL pulse timeout_err, drop uart_transmit, return to IDLE; last_grant keeps the new value.
REQ-021 WAIT_DONE: on sampled uart_is_transmitting=0, SHALL return to IDLE; earliest next grant is the following edge.
REQ-022 Grant-to-grant minimum SHALL be 3 cycles plus UART frame time; at most one byte in flight.
REQ-023 uart_tx_byte and grant_id SHALL hold their value until the next grant.

Reset
REQ-024 On rst: state IDLE, req_ready=0, uart_transmit=0, uart_tx_byte=0, grant_id=0, busy=0, timeout_err=0, counter=0, last_grant=NREQ-1 (requester 0 wins first).
REQ-025 Reset mid-LAUNCH/WAIT_DONE SHALL abort immediately (asynchronously); no req_ready re-issued for the aborted byte.

Configuration
REQ-026 With UART_TX_ARB_FIXED_PRIO_EN defined, arbitration SHALL be fixed priority (lowest index wins) and last_grant SHALL be removed; without it, round-robin per REQ-018.

Structure
REQ-027 Shared package uart_pkg SHALL hold the FSM state typedef, 8-bit byte typedef and default START_TIMEOUT constant.
REQ-028 Winner selection SHALL be a combinational sub-module uart_arb_pick (inputs req_valid, last_grant; outputs one-hot winner, index, any).

Verification
REQ-029 Single: req_valid=0001, data0=8'h03, UART model busy 2 cycles after transmit for 10 cycles -> req_ready=0001 one cycle, uart_tx_byte=8'h03, transmit drops after busy seen, busy=0 after.
REQ-030 Round-robin: all 4 valid continuously, data i=8'h10+i -> grant order 0,1,2,3,0; with FIXED_PRIO_EN order 0,0,0,0.
REQ-031 Timeout: UART model never asserts busy -> timeout_err pulse exactly 15 cycles after launch, uart_transmit=0, next request served afterward.
REQ-032 Busy hold-off: uart_is_transmitting=1 externally in IDLE, req_valid=0010 -> no req_ready until busy falls, then grant 1 next edge.
REQ-033 Reset mid-transfer: rst pulsed in WAIT_DONE -> all outputs zero same cycle, requester 0 granted first after release.
REQ-034 Loopback: 5 bytes 8'h03..8'h07 via requester 2 to a second UART -> receiver gets 03,04,05,06,07 in order, no recv_error.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit arbiter.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_DONE = 2'd2
  } state_t;

  typedef logic [7:0] byte_t;

  localparam int unsigned START_TIMEOUT_DEF = 15;

  // Index width for n requesters, never below one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_arb_pick.sv
// Combinational winner selection for uart_tx_arb.
// UART_TX_ARB_FIXED_PRIO_EN selects lowest-index priority; otherwise round-robin after last_grant.
module uart_arb_pick
  import uart_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  localparam int unsigned IW = idx_w(NREQ)
) (
  input  logic [NREQ-1:0] req_valid,
`ifndef UART_TX_ARB_FIXED_PRIO_EN
  input  logic [IW-1:0]   last_grant,
`endif
  output logic [NREQ-1:0] winner,
  output logic [IW-1:0]   index,
  output logic            any
);

  logic [IW-1:0] cand;

`ifdef UART_TX_ARB_FIXED_PRIO_EN
  always_comb begin
    winner = '0;
    index  = '0;
    any    = 1'b0;
    cand   = '0;
    for (int k = 0; k < int'(NREQ); k++) begin
      cand = IW'(k);
      if (!any && req_valid[cand]) begin
        any           = 1'b1;
        index         = cand;
        winner[cand]  = 1'b1;
      end
    end
  end
`else
  // Search starts one past the previous winner and wraps.
  always_comb begin
    winner = '0;
    index  = '0;
    any    = 1'b0;
    cand   = '0;
    for (int k = 1; k <= int'(NREQ); k++) begin
      cand = IW'((int'(last_grant) + k) % int'(NREQ));
      if (!any && req_valid[cand]) begin
        any           = 1'b1;
        index         = cand;
        winner[cand]  = 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/uart_tx_arb.sv
// Shares one UART transmitter among NREQ byte requesters, one byte in flight at a time.
// Define UART_TX_ARB_FIXED_PRIO_EN for fixed lowest-index priority instead of round-robin.
module uart_tx_arb
  import uart_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  parameter int unsigned START_TIMEOUT = START_TIMEOUT_DEF,
  localparam int unsigned IW = idx_w(NREQ)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*8-1:0] req_data,
  output logic [NREQ-1:0]   req_ready,
  output logic              uart_transmit,
  output byte_t             uart_tx_byte,
  input  logic              uart_is_transmitting,
  output logic [IW-1:0]     grant_id,
  output logic              busy,
  output logic              timeout_err
);

  localparam int unsigned CW = idx_w(START_TIMEOUT + 1);

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [NREQ-1:0] pick_winner;
  logic [IW-1:0]   pick_idx;
  logic            pick_any;
  byte_t           pick_data;

`ifndef UART_TX_ARB_FIXED_PRIO_EN
  logic [IW-1:0]   last_grant;
`endif

  uart_arb_pick #(.NREQ(NREQ)) u_pick (
    .req_valid  (req_valid),
`ifndef UART_TX_ARB_FIXED_PRIO_EN
    .last_grant (last_grant),
`endif
    .winner     (pick_winner),
    .index      (pick_idx),
    .any        (pick_any)
  );

  // One-hot mux of the winning requester's byte.
  always_comb begin
    pick_data = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      if (pick_winner[i]) pick_data = pick_data | req_data[8*i +: 8];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      req_ready     <= '0;
      uart_transmit <= 1'b0;
      uart_tx_byte  <= '0;
      grant_id      <= '0;
      busy          <= 1'b0;
      timeout_err   <= 1'b0;
`ifndef UART_TX_ARB_FIXED_PRIO_EN
      last_grant    <= IW'(NREQ - 1);
`endif
    end else begin
      req_ready   <= '0;
      timeout_err <= 1'b0;
      unique case (state)
        IDLE: begin
          if (pick_any && !uart_is_transmitting) begin
            state         <= LAUNCH;
            busy          <= 1'b1;
            uart_transmit <= 1'b1;
            uart_tx_byte  <= pick_data;
            grant_id      <= pick_idx;
            req_ready     <= pick_winner;
            cnt           <= '0;
`ifndef UART_TX_ARB_FIXED_PRIO_EN
            last_grant    <= pick_idx;
`endif
          end
        end
        LAUNCH: begin
          if (uart_is_transmitting) begin
            uart_transmit <= 1'b0;
            state         <= WAIT_DONE;
          end else if (cnt == CW'(START_TIMEOUT - 1)) begin
            // UART never picked the byte up; give up and free the channel.
            uart_transmit <= 1'b0;
            timeout_err   <= 1'b1;
            busy          <= 1'b0;
            state         <= IDLE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        WAIT_DONE: begin
          if (!uart_is_transmitting) begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          state         <= IDLE;
          busy          <= 1'b0;
          uart_transmit <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arb.sv
// Directed and randomized checks of uart_tx_arb against a UART model and an arbitration reference.
module tb_uart_tx_arb;

  localparam int unsigned NREQ = 4;
  localparam int unsigned IW   = 2;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic [NREQ-1:0]     req_valid = '0;
  logic [7:0]          dat [NREQ];
  logic [NREQ*8-1:0]   req_data;
  logic [NREQ-1:0]     req_ready;
  logic                uart_transmit;
  logic [7:0]          uart_tx_byte;
  logic                uart_is_transmitting;
  logic [IW-1:0]       grant_id;
  logic                busy;
  logic                timeout_err;

  int total = 0;
  int bad   = 0;

  // UART model knobs and state
  int   lat_cfg = 1;
  int   len_cfg = 10;
  bit   never_busy = 1'b0;
  bit   ext_busy = 1'b0;
  int   m_phase = 0;
  int   m_cnt = 0;
  int   m_len = 0;
  logic m_busy = 1'b0;
  logic [7:0] rx_log [256];
  int   rx_n = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NREQ; g++) begin : g_data
    assign req_data[8*g +: 8] = dat[g];
  end

  assign uart_is_transmitting = m_busy | ext_busy;

  uart_tx_arb dut (
    .clk                  (clk),
    .rst                  (rst),
    .req_valid            (req_valid),
    .req_data             (req_data),
    .req_ready            (req_ready),
    .uart_transmit        (uart_transmit),
    .uart_tx_byte         (uart_tx_byte),
    .uart_is_transmitting (uart_is_transmitting),
    .grant_id             (grant_id),
    .busy                 (busy),
    .timeout_err          (timeout_err)
  );

  // Receiving UART: latch byte on transmit, go busy after lat_cfg, stay busy len_cfg cycles.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase <= 0;
      m_cnt   <= 0;
      m_len   <= 0;
      m_busy  <= 1'b0;
    end else begin
      case (m_phase)
        0: if (uart_transmit && !never_busy) begin
             rx_log[rx_n[7:0]] <= uart_tx_byte;
             rx_n    <= rx_n + 1;
             m_cnt   <= lat_cfg;
             m_len   <= len_cfg;
             m_phase <= 1;
           end
        1: if (m_cnt == 0) begin
             m_busy  <= 1'b1;
             m_cnt   <= m_len;
             m_phase <= 2;
           end else m_cnt <= m_cnt - 1;
        2: if (m_cnt <= 1) begin
             m_busy  <= 1'b0;
             m_phase <= 3;
           end else m_cnt <= m_cnt - 1;
        default: if (!uart_transmit) m_phase <= 0;
      endcase
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int onehot_idx(input logic [NREQ-1:0] v);
    for (int i = 0; i < int'(NREQ); i++) if (1'(v >> i)) return i;
    return -1;
  endfunction

  // Reference arbitration: which valid requester should win given the previous winner.
  function automatic int ref_pick(input logic [NREQ-1:0] v, input int last);
`ifdef UART_TX_ARB_FIXED_PRIO_EN
    for (int i = 0; i < int'(NREQ); i++) if (1'(v >> i)) return i;
`else
    for (int k = 1; k <= int'(NREQ); k++) if (1'(v >> ((last + k) % int'(NREQ)))) return (last + k) % int'(NREQ);
`endif
    return -1;
  endfunction

  task automatic wait_grant(input int bound, output int id);
    id = -1;
    for (int c = 0; c < bound && id < 0; c++) begin
      tick();
      if (req_ready != '0) id = onehot_idx(req_ready);
    end
    if (id < 0) chk("grant_wait_expired", 32'd0, 32'd1);
  endtask

  task automatic wait_idle(input int bound);
    int c;
    c = 0;
    while (c < bound && (busy || uart_is_transmitting)) begin
      tick();
      c++;
    end
    if (busy || uart_is_transmitting) chk("idle_wait_expired", 32'd0, 32'd1);
  endtask

  initial begin
    int id, base, last, exp_w, k;
    bit hold_ok, seen;
    logic [NREQ-1:0] exp_ready;
    logic [7:0] exp_q [$];

    for (int i = 0; i < int'(NREQ); i++) dat[i] = 8'h00;

    // Reset state
    tick(); tick(); tick();
    rst = 1'b0;
    tick();
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_transmit", 32'(uart_transmit), 32'd0);
    chk("rst_tx_byte", 32'(uart_tx_byte), 32'd0);
    chk("rst_grant_id", 32'(grant_id), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_timeout", 32'(timeout_err), 32'd0);

    // Single byte from requester 0
    lat_cfg = 1; len_cfg = 10;
    dat[0] = 8'h03; req_valid = 4'b0001;
    wait_grant(5, id);
    chk("single_ready", 32'(req_ready), 32'h1);
    chk("single_byte", 32'(uart_tx_byte), 32'h03);
    chk("single_gid", 32'(grant_id), 32'd0);
    chk("single_xmit", 32'(uart_transmit), 32'd1);
    chk("single_busy", 32'(busy), 32'd1);
    req_valid = '0;
    tick();
    chk("single_ready_pulse", 32'(req_ready), 32'd0);
    hold_ok = 1'b1;
    for (int c = 0; c < 20 && !uart_is_transmitting; c++) begin
      hold_ok &= uart_transmit;
      tick();
    end
    chk("launch_seen_busy", 32'(uart_is_transmitting), 32'd1);
    chk("launch_hold", 32'(hold_ok & uart_transmit), 32'd1);
    tick();
    chk("xmit_drop", 32'(uart_transmit), 32'd0);
    chk("wait_busy", 32'(busy), 32'd1);
    for (int c = 0; c < 30 && uart_is_transmitting; c++) tick();
    chk("frame_end", 32'(uart_is_transmitting), 32'd0);
    chk("busy_before_idle", 32'(busy), 32'd1);
    tick();
    chk("busy_after_idle", 32'(busy), 32'd0);

    // Launch timeout on requester 2
    never_busy = 1'b1;
    dat[2] = 8'hA5; req_valid = 4'b0100;
    wait_grant(5, id);
    chk("tmo_gid", 32'(id), 32'd2);
    req_valid = '0;
    k = 0; seen = 1'b0;
    for (int c = 1; c <= 20 && !seen; c++) begin
      tick();
      if (timeout_err) begin seen = 1'b1; k = c; end
    end
    chk("tmo_cycle", 32'(k), 32'd15);
    chk("tmo_xmit", 32'(uart_transmit), 32'd0);
    chk("tmo_busy", 32'(busy), 32'd0);
    tick();
    chk("tmo_pulse", 32'(timeout_err), 32'd0);
    never_busy = 1'b0;
    dat[1] = 8'h5A; req_valid = 4'b0010;
    wait_grant(5, id);
    chk("after_tmo_gid", 32'(id), 32'd1);
    chk("after_tmo_byte", 32'(uart_tx_byte), 32'h5A);
    req_valid = '0;
    wait_idle(40);

    // External busy hold-off
    ext_busy = 1'b1;
    dat[1] = 8'h77; req_valid = 4'b0010;
    seen = 1'b0;
    for (int c = 0; c < 6; c++) begin
      tick();
      seen |= (req_ready != '0);
    end
    chk("holdoff_no_grant", 32'(seen), 32'd0);
    ext_busy = 1'b0;
    tick();
    chk("holdoff_grant", 32'(req_ready), 32'h2);
    chk("holdoff_byte", 32'(uart_tx_byte), 32'h77);
    req_valid = '0;
    wait_idle(40);

    // Reset during WAIT_DONE
    lat_cfg = 0; len_cfg = 40;
    dat[3] = 8'h99; req_valid = 4'b1000;
    wait_grant(5, id);
    chk("pre_rst_gid", 32'(id), 32'd3);
    req_valid = '0;
    for (int c = 0; c < 20 && !(busy && !uart_transmit); c++) tick();
    chk("in_wait_done", 32'(busy && !uart_transmit), 32'd1);
    #1 rst = 1'b1;
    #1 chk("async_rst_outs", 32'({req_ready, uart_transmit, uart_tx_byte, grant_id, busy, timeout_err}), 32'd0);
    tick();
    rst = 1'b0;

    // All requesters valid continuously
    len_cfg = 3;
    for (int i = 0; i < int'(NREQ); i++) dat[i] = 8'h10 + 8'(i);
    req_valid = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      wait_grant(40, id);
`ifdef UART_TX_ARB_FIXED_PRIO_EN
      chk("order", 32'(id), 32'd0);
`else
      chk("order", 32'(id), 32'(n % int'(NREQ)));
`endif
      chk("order_byte", 32'(uart_tx_byte), 32'h10 + 32'(id));
    end
    req_valid = '0;
    wait_idle(40);

    // Five bytes through requester 2 in order
    lat_cfg = 1; len_cfg = 4;
    base = rx_n;
    for (int b = 0; b < 5; b++) begin
      dat[2] = 8'h03 + 8'(b); req_valid = 4'b0100;
      wait_grant(40, id);
      chk("loop_gid", 32'(id), 32'd2);
      req_valid = '0;
      wait_idle(40);
    end
    chk("loop_count", 32'(rx_n - base), 32'd5);
    for (int b = 0; b < 5; b++) chk("loop_byte", 32'(rx_log[8'(base + b)]), 32'h03 + 32'(b));

    // Randomized traffic against the reference arbiter
    rst = 1'b1; tick(); rst = 1'b0;
    last = int'(NREQ) - 1;
    base = rx_n;
    exp_ready = '0; exp_w = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      tick();
      chk("rnd_ready", 32'(req_ready), 32'(exp_ready));
      if (exp_ready != '0) begin
        chk("rnd_byte", 32'(uart_tx_byte), 32'(dat[IW'(exp_w)]));
        chk("rnd_gid", 32'(grant_id), 32'(exp_w));
        last = exp_w;
        exp_q.push_back(dat[IW'(exp_w)]);
        req_valid = req_valid & ~(NREQ'(1) << exp_w);
      end
      lat_cfg = int'($urandom_range(0, 4));
      len_cfg = int'($urandom_range(1, 6));
      for (int i = 0; i < int'(NREQ); i++) begin
        if (!1'(req_valid >> i)) begin
          if ($urandom_range(0, 3) == 0) begin
            dat[IW'(i)] = 8'($urandom);
            req_valid = req_valid | (NREQ'(1) << i);
          end
        end else if ($urandom_range(0, 15) == 0) begin
          req_valid = req_valid & ~(NREQ'(1) << i);
        end
      end
      if (!busy && !uart_is_transmitting && req_valid != '0) begin
        exp_w = ref_pick(req_valid, last);
        exp_ready = NREQ'(1) << exp_w;
      end else begin
        exp_ready = '0;
      end
    end
    req_valid = '0;
    tick();
    wait_idle(60);
    chk("rnd_rx_count", 32'(rx_n - base), 32'(exp_q.size()));
    for (int j = 0; j < exp_q.size() && j < rx_n - base; j++)
      chk("rnd_rx_byte", 32'(rx_log[8'(base + j)]), 32'(exp_q[j]));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
